// File: rtl/hub_pkg.sv
// Shared definitions for the leaf hub: tag widths, broadcast ID and downstream FSM states.
package hub_pkg;

    localparam logic [1:0] DS_IDLE    = 2'd0;
    localparam logic [1:0] DS_UNICAST = 2'd1;
    localparam logic [1:0] DS_BCAST   = 2'd2;

    typedef logic [1:0] ds_state_t;

    // Tag must encode every leaf plus one spare all-ones code for broadcast.
    function automatic int unsigned leaf_id_width(input int unsigned leaf_count);
        return $clog2(leaf_count + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned leaf_count);
        return (leaf_count > 1) ? $clog2(leaf_count) : 1;
    endfunction

    function automatic int unsigned broadcast_id(input int unsigned id_width);
        return (1 << id_width) - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first active request at or after ptr, searched cyclically.
module rr_arbiter
    import hub_pkg::*;
#(
    parameter int unsigned  LEAF_COUNT = 2,
    localparam int unsigned IDX_WIDTH  = idx_width(LEAF_COUNT)
) (
    input  logic [LEAF_COUNT-1:0] req,
    input  logic [IDX_WIDTH-1:0]  ptr,
    output logic [LEAF_COUNT-1:0] grant,
    output logic [IDX_WIDTH-1:0]  grant_idx,
    output logic                  grant_valid
);

    logic [IDX_WIDTH-1:0] cand;

    always_comb begin
        cand        = '0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned off = 0; off < LEAF_COUNT; off++) begin
            cand = IDX_WIDTH'((32'(ptr) + off) % LEAF_COUNT);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_hub_arbiter.sv
// Hub link controller: round-robin merges leaf messages toward the root and routes
// root messages to one leaf or broadcasts them to all leaves.
module leaf_hub_arbiter
    import hub_pkg::*;
#(
    parameter int unsigned  LEAF_COUNT     = 2,
    parameter int unsigned  HUB_FIFO_WIDTH = 16,
    localparam int unsigned LEAF_ID_WIDTH  = leaf_id_width(LEAF_COUNT),
    localparam int unsigned MSG_WIDTH      = LEAF_ID_WIDTH + HUB_FIFO_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [HUB_FIFO_WIDTH*LEAF_COUNT-1:0] leaf_out_data,
    input  logic [LEAF_COUNT-1:0]                leaf_out_valid,
    output logic [LEAF_COUNT-1:0]                leaf_out_ready,
    output logic [HUB_FIFO_WIDTH*LEAF_COUNT-1:0] leaf_in_data,
    output logic [LEAF_COUNT-1:0]                leaf_in_valid,
    input  logic [LEAF_COUNT-1:0]                leaf_in_ready,
    output logic [MSG_WIDTH-1:0]                 root_out_data,
    output logic                                 root_out_valid,
    input  logic                                 root_out_ready,
    input  logic [MSG_WIDTH-1:0]                 root_in_data,
    input  logic                                 root_in_valid,
    output logic                                 root_in_ready,
    output logic                                 has_flying_messages,
    output logic                                 route_error
);

    localparam int unsigned IDX_WIDTH = idx_width(LEAF_COUNT);
    localparam int unsigned BCAST_ID  = broadcast_id(LEAF_ID_WIDTH);

    // Upstream: arbiter feeding a one-entry output register

    logic [HUB_FIFO_WIDTH-1:0] leaf_payload [LEAF_COUNT];
    logic [LEAF_COUNT-1:0]     grant;
    logic [IDX_WIDTH-1:0]      grant_idx;
    logic                      grant_valid;
    logic [IDX_WIDTH-1:0]      rr_ptr;
    logic [IDX_WIDTH-1:0]      ptr_next;
    logic                      up_can_load;
    logic                      up_accept;
    logic [MSG_WIDTH-1:0]      up_data;
    logic                      up_valid;

    for (genvar g = 0; g < LEAF_COUNT; g++) begin : g_payload
        assign leaf_payload[g] = leaf_out_data[g*HUB_FIFO_WIDTH +: HUB_FIFO_WIDTH];
    end

    rr_arbiter #(
        .LEAF_COUNT (LEAF_COUNT)
    ) u_rr_arbiter (
        .req         (leaf_out_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Register can take a new word when empty or when its current word leaves this cycle.
    assign up_can_load    = !up_valid || root_out_ready;
    assign up_accept      = up_can_load && grant_valid;
    assign leaf_out_ready = up_can_load ? grant : '0;
    assign ptr_next       = (32'(grant_idx) == LEAF_COUNT - 1) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_valid <= 1'b0;
            up_data  <= '0;
            rr_ptr   <= '0;
        end else if (up_accept) begin
            up_valid <= 1'b1;
            up_data  <= {LEAF_ID_WIDTH'(grant_idx), leaf_payload[grant_idx]};
            rr_ptr   <= ptr_next;
        end else if (root_out_ready) begin
            up_valid <= 1'b0;
        end
    end

    assign root_out_data  = up_data;
    assign root_out_valid = up_valid;

    // Downstream: routing FSM

    ds_state_t                 ds_state, ds_next;
    logic [LEAF_COUNT-1:0]     dn_valid, dn_valid_next;
    logic [HUB_FIFO_WIDTH-1:0] dn_payload, dn_payload_next;
    logic [IDX_WIDTH-1:0]      dn_dest, dn_dest_next;
    logic                      err_q, err_next;
    logic [LEAF_ID_WIDTH-1:0]  in_dest;
    logic [HUB_FIFO_WIDTH-1:0] in_payload;
    logic                      dest_is_leaf;
    logic                      dest_is_bcast;
    logic [LEAF_COUNT-1:0]     dest_onehot;

    assign in_dest       = root_in_data[MSG_WIDTH-1 -: LEAF_ID_WIDTH];
    assign in_payload    = root_in_data[HUB_FIFO_WIDTH-1:0];
    assign dest_is_leaf  = 32'(in_dest) < LEAF_COUNT;
    assign dest_is_bcast = 32'(in_dest) == BCAST_ID;
    assign dest_onehot   = LEAF_COUNT'(1) << in_dest;

    // In BCAST the valid vector doubles as the mask of leaves still owed the message.
    always_comb begin
        ds_next         = ds_state;
        dn_valid_next   = dn_valid;
        dn_payload_next = dn_payload;
        dn_dest_next    = dn_dest;
        err_next        = err_q;
        case (ds_state)
            DS_IDLE: begin
                if (root_in_valid) begin
                    if (dest_is_leaf) begin
                        dn_payload_next = in_payload;
                        dn_dest_next    = IDX_WIDTH'(in_dest);
                        dn_valid_next   = dest_onehot;
                        ds_next         = DS_UNICAST;
                    end else if (dest_is_bcast) begin
                        dn_payload_next = in_payload;
                        dn_valid_next   = '1;
                        ds_next         = DS_BCAST;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            DS_UNICAST: begin
                if (leaf_in_ready[dn_dest]) begin
                    dn_valid_next = '0;
                    ds_next       = DS_IDLE;
                end
            end
            DS_BCAST: begin
                dn_valid_next = dn_valid & ~leaf_in_ready;
                if (dn_valid_next == '0) begin
                    ds_next = DS_IDLE;
                end
            end
            default: begin
                dn_valid_next = '0;
                ds_next       = DS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ds_state   <= DS_IDLE;
            dn_valid   <= '0;
            dn_payload <= '0;
            dn_dest    <= '0;
            err_q      <= 1'b0;
        end else begin
            ds_state   <= ds_next;
            dn_valid   <= dn_valid_next;
            dn_payload <= dn_payload_next;
            dn_dest    <= dn_dest_next;
            err_q      <= err_next;
        end
    end

    assign leaf_in_data  = {LEAF_COUNT{dn_payload}};
    assign leaf_in_valid = dn_valid;
    assign root_in_ready = (ds_state == DS_IDLE);
    assign route_error   = err_q;

    assign has_flying_messages = up_valid | (|dn_valid) | (|leaf_out_valid) | root_in_valid;

endmodule
